// File: rtl/cpu_datapath.sv
// 8-bit CPU datapath: register file R0-R3, PC, IR, address register, ALU operand Y
// and zero/overflow flags, connected by two internal buses and driving a single-port
// memory. All control comes cycle-by-cycle from the controller FSM.
// Optional build macro DP_SIGNED_OVF_EN: ADD/SUB overflow uses the two's-complement
// signed rule instead of unsigned carry/borrow.
module cpu_datapath #(
  parameter int unsigned       WIDTH  = 8,
  parameter logic [WIDTH-1:0]  PC_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_r0,
  input  logic             load_r1,
  input  logic             load_r2,
  input  logic             load_r3,
  input  logic             load_pc,
  input  logic             inc_pc,
  input  logic             load_ir,
  input  logic             load_a_reg,
  input  logic             load_reg_y,
  input  logic             load_reg_z,
  input  logic             write,
  input  logic [2:0]       s_b_mux1,
  input  logic [1:0]       s_b_mux2,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] instruction,
  output logic             zero,
  output logic             over
);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpNot = 4'h3;
  localparam logic [3:0] OpOr  = 4'h4;
  localparam logic [3:0] OpMul = 4'h5;

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r0_q, r1_q, r2_q, r3_q;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ar_q, y_q;
  logic             zero_q, over_q;

  logic [WIDTH-1:0]   bus1, bus2;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_over;
  logic               alu_zero;
  logic [3:0]         opcode;
  logic [2*WIDTH-1:0] mul_full;

  assign opcode   = ir_q[7:4];
  assign mul_full = {{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, bus1};

`ifndef DP_SIGNED_OVF_EN
  logic [WIDTH:0] add_full;
  assign add_full = {1'b0, y_q} + {1'b0, bus1};
`endif

  // Bus1 source select: general registers or PC, unused codes read as zero.
  always_comb begin
    bus1 = '0;
    case (s_b_mux1)
      3'b000:  bus1 = r0_q;
      3'b001:  bus1 = r1_q;
      3'b010:  bus1 = r2_q;
      3'b011:  bus1 = r3_q;
      3'b100:  bus1 = pc_q;
      default: bus1 = '0;
    endcase
  end

  // Bus2 source select: ALU, bus1 pass-through, memory, or zero.
  always_comb begin
    bus2 = '0;
    case (s_b_mux2)
      2'b00:   bus2 = alu_res;
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = mem_rdata;
      default: bus2 = '0;
    endcase
  end

  // ALU: A = Y, B = bus1, operation decoded from IR[7:4].
  always_comb begin
    alu_res  = '0;
    alu_over = 1'b0;
    case (opcode)
      OpAdd: begin
`ifdef DP_SIGNED_OVF_EN
        alu_res  = y_q + bus1;
        alu_over = (y_q[WIDTH-1] == bus1[WIDTH-1]) && (alu_res[WIDTH-1] != y_q[WIDTH-1]);
`else
        alu_res  = add_full[WIDTH-1:0];
        alu_over = add_full[WIDTH];
`endif
      end
      OpSub: begin
        alu_res  = y_q - bus1;
`ifdef DP_SIGNED_OVF_EN
        alu_over = (y_q[WIDTH-1] != bus1[WIDTH-1]) && (alu_res[WIDTH-1] != y_q[WIDTH-1]);
`else
        alu_over = (y_q < bus1);
`endif
      end
      OpAnd: alu_res = y_q & bus1;
      OpNot: alu_res = ~y_q;
      OpOr:  alu_res = y_q | bus1;
      OpMul: begin
        alu_res  = mul_full[WIDTH-1:0];
        alu_over = |mul_full[2*WIDTH-1:WIDTH];
      end
      default: begin
        alu_res  = '0;
        alu_over = 1'b0;
      end
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // PC next state: load beats increment; increment wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (load_pc) begin
      pc_d = bus2;
    end else if (inc_pc) begin
      pc_d = pc_q + One;
    end
  end

  // General-purpose registers capture bus2 when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else begin
      if (load_r0) r0_q <= bus2;
      if (load_r1) r1_q <= bus2;
      if (load_r2) r2_q <= bus2;
      if (load_r3) r3_q <= bus2;
    end
  end

  // Control registers: PC, IR, address register and ALU operand Y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_RST;
      ir_q <= '0;
      ar_q <= '0;
      y_q  <= '0;
    end else begin
      pc_q <= pc_d;
      if (load_ir)    ir_q <= bus2;
      if (load_a_reg) ar_q <= bus2;
      if (load_reg_y) y_q  <= bus2;
    end
  end

  // Flags update together, only on explicit request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      over_q <= 1'b0;
    end else if (load_reg_z) begin
      zero_q <= alu_zero;
      over_q <= alu_over;
    end
  end

  assign mem_addr    = ar_q;
  assign mem_wdata   = bus1;
  assign mem_we      = write;
  assign instruction = ir_q;
  assign zero        = zero_q;
  assign over        = over_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath with a small behavioural memory.
module tb_cpu_datapath;

  logic       clk;
  logic       rst;
  logic       load_r0, load_r1, load_r2, load_r3;
  logic       load_pc, inc_pc, load_ir, load_a_reg, load_reg_y, load_reg_z;
  logic       write;
  logic [2:0] s_b_mux1;
  logic [1:0] s_b_mux2;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] instruction;
  logic       zero;
  logic       over;

  logic [7:0] mem [256];
  logic       use_force;
  logic [7:0] force_val;

  int errors = 0;
  int checks = 0;

  cpu_datapath #(
    .WIDTH (8),
    .PC_RST(8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_r0    (load_r0),
    .load_r1    (load_r1),
    .load_r2    (load_r2),
    .load_r3    (load_r3),
    .load_pc    (load_pc),
    .inc_pc     (inc_pc),
    .load_ir    (load_ir),
    .load_a_reg (load_a_reg),
    .load_reg_y (load_reg_y),
    .load_reg_z (load_reg_z),
    .write      (write),
    .s_b_mux1   (s_b_mux1),
    .s_b_mux2   (s_b_mux2),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .instruction(instruction),
    .zero       (zero),
    .over       (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forced value lets the bench place any constant on bus2 without a memory setup.
  assign mem_rdata = use_force ? force_val : mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    {load_r0, load_r1, load_r2, load_r3} = '0;
    {load_pc, inc_pc, load_ir, load_a_reg, load_reg_y, load_reg_z} = '0;
    write     = 1'b0;
    s_b_mux1  = 3'b101;
    s_b_mux2  = 2'b11;
    use_force = 1'b0;
    force_val = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] v);
    use_force = 1'b1;
    force_val = v;
    s_b_mux2  = 2'b10;
  endtask

  // which: 0-3 = Rn, 4 = PC, 5 = IR, 6 = address reg, 7 = Y
  task automatic load_val(input int which, input logic [7:0] v);
    idle();
    put(v);
    case (which)
      0: load_r0 = 1'b1;
      1: load_r1 = 1'b1;
      2: load_r2 = 1'b1;
      3: load_r3 = 1'b1;
      4: load_pc = 1'b1;
      5: load_ir = 1'b1;
      6: load_a_reg = 1'b1;
      default: load_reg_y = 1'b1;
    endcase
    tick();
    idle();
  endtask

  task automatic rd(input string tag, input logic [2:0] sel, input logic [7:0] exp);
    s_b_mux1 = sel;
    #1;
    check(tag, {8'h00, mem_wdata}, {8'h00, exp});
    s_b_mux1 = 3'b101;
  endtask

  // Run the ALU into R0 with flags captured, B operand from the given bus1 source.
  task automatic alu_op(input logic [2:0] bsel);
    idle();
    load_r0    = 1'b1;
    load_reg_z = 1'b1;
    s_b_mux1   = bsel;
    s_b_mux2   = 2'b00;
    tick();
    idle();
  endtask

  logic exp_ovf;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h07;
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;

    // Preload everything with 0x5A, then set flags via MUL 5A*5A (over=1).
    idle();
    put(8'h5A);
    {load_r0, load_r1, load_r2, load_r3} = '1;
    {load_pc, load_ir, load_a_reg, load_reg_y} = '1;
    tick();
    idle();
    check("pre_addr", {8'h00, mem_addr}, 16'h005A);
    check("pre_ir", {8'h00, instruction}, 16'h005A);
    alu_op(3'b001);
    check("pre_over", {15'h0, over}, 16'h1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("rst_addr", {8'h00, mem_addr}, 16'h0000);
    check("rst_ir", {8'h00, instruction}, 16'h0000);
    check("rst_zero", {15'h0, zero}, 16'h0);
    check("rst_over", {15'h0, over}, 16'h0);
    write = 1'b1;
    #1;
    check("rst_we", {15'h0, mem_we}, 16'h1);
    write = 1'b0;
    rd("rst_r0", 3'b000, 8'h00);
    rd("rst_r1", 3'b001, 8'h00);
    rd("rst_r2", 3'b010, 8'h00);
    rd("rst_r3", 3'b011, 8'h00);
    rd("rst_pc", 3'b100, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    // Y=0, IR=0 (ADD), B=0 -> zero=1, over=0 confirms Y cleared.
    alu_op(3'b101);
    check("rst_y_zero", {15'h0, zero}, 16'h1);
    check("rst_y_over", {15'h0, over}, 16'h0);

    // Instruction fetch.
    load_val(4, 8'h10);
    idle();
    load_a_reg = 1'b1;
    s_b_mux1   = 3'b100;
    s_b_mux2   = 2'b01;
    tick();
    idle();
    check("fetch_addr", {8'h00, mem_addr}, 16'h0010);
    load_ir  = 1'b1;
    inc_pc   = 1'b1;
    s_b_mux2 = 2'b10;
    tick();
    idle();
    check("fetch_ir", {8'h00, instruction}, 16'h0007);
    rd("fetch_pc", 3'b100, 8'h11);

    // ADD with carry: F0 + 10.
    load_val(7, 8'hF0);
    load_val(1, 8'h10);
    load_val(5, 8'h01);
    alu_op(3'b001);
    rd("add_r0", 3'b000, 8'h00);
    check("add_zero", {15'h0, zero}, 16'h1);
`ifdef DP_SIGNED_OVF_EN
    exp_ovf = 1'b0;
`else
    exp_ovf = 1'b1;
`endif
    check("add_over", {15'h0, over}, {15'h0, exp_ovf});

    // SUB 05 - 07: unsigned borrow, no signed overflow.
    load_val(7, 8'h05);
    load_val(1, 8'h07);
    load_val(5, 8'h10);
    alu_op(3'b001);
    rd("sub1_r0", 3'b000, 8'hFE);
`ifdef DP_SIGNED_OVF_EN
    exp_ovf = 1'b0;
`else
    exp_ovf = 1'b1;
`endif
    check("sub1_over", {15'h0, over}, {15'h0, exp_ovf});

    // SUB 80 - 01: no borrow, signed overflow.
    load_val(7, 8'h80);
    load_val(1, 8'h01);
    alu_op(3'b001);
    rd("sub2_r0", 3'b000, 8'h7F);
`ifdef DP_SIGNED_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    check("sub2_over", {15'h0, over}, {15'h0, exp_ovf});

    // MUL 10 * 11 = 0x110.
    load_val(7, 8'h10);
    load_val(2, 8'h11);
    load_val(5, 8'h52);
    alu_op(3'b010);
    rd("mul1_r0", 3'b000, 8'h10);
    check("mul1_zero", {15'h0, zero}, 16'h0);
    check("mul1_over", {15'h0, over}, 16'h1);

    // Flags hold across a non-flag load.
    load_val(3, 8'h00);
    check("hold_over", {15'h0, over}, 16'h1);

    // MUL 03 * 04.
    load_val(7, 8'h03);
    load_val(2, 8'h04);
    alu_op(3'b010);
    rd("mul2_r0", 3'b000, 8'h0C);
    check("mul2_zero", {15'h0, zero}, 16'h0);
    check("mul2_over", {15'h0, over}, 16'h0);

    // OR 0F | F0.
    load_val(7, 8'h0F);
    load_val(1, 8'hF0);
    load_val(5, 8'h40);
    alu_op(3'b001);
    rd("or_r0", 3'b000, 8'hFF);
    check("or_zero", {15'h0, zero}, 16'h0);

    // NOT FF -> 00.
    load_val(7, 8'hFF);
    load_val(5, 8'h30);
    alu_op(3'b001);
    rd("not_r0", 3'b000, 8'h00);
    check("not_zero", {15'h0, zero}, 16'h1);

    // Undefined opcode yields zero.
    load_val(7, 8'h55);
    load_val(5, 8'h60);
    alu_op(3'b001);
    rd("inv_r0", 3'b000, 8'h00);
    check("inv_zero", {15'h0, zero}, 16'h1);

    // bus2 select 11 loads zero.
    idle();
    load_r2  = 1'b1;
    s_b_mux1 = 3'b000;
    s_b_mux2 = 2'b11;
    tick();
    idle();
    rd("bus2_zero", 3'b010, 8'h00);

    // Memory write.
    load_val(6, 8'h20);
    load_val(3, 8'hA5);
    write    = 1'b1;
    s_b_mux1 = 3'b011;
    #1;
    check("wr_we", {15'h0, mem_we}, 16'h1);
    check("wr_wdata", {8'h00, mem_wdata}, 16'h00A5);
    check("wr_addr", {8'h00, mem_addr}, 16'h0020);
    tick();
    idle();
    check("wr_mem", {8'h00, mem[8'h20]}, 16'h00A5);
    rd("wr_r3", 3'b011, 8'hA5);
    check("wr_addr_hold", {8'h00, mem_addr}, 16'h0020);

    // PC wrap and load priority.
    load_val(4, 8'hFF);
    inc_pc = 1'b1;
    tick();
    idle();
    rd("pc_wrap", 3'b100, 8'h00);
    put(8'h42);
    load_pc = 1'b1;
    inc_pc  = 1'b1;
    tick();
    idle();
    rd("pc_prio", 3'b100, 8'h42);

    // Increment with PC on bus1 sees the pre-increment value.
    load_r1  = 1'b1;
    inc_pc   = 1'b1;
    s_b_mux1 = 3'b100;
    s_b_mux2 = 2'b01;
    tick();
    idle();
    rd("preinc_r1", 3'b001, 8'h42);
    rd("preinc_pc", 3'b100, 8'h43);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 8-bit datapath driven cycle-by-cycle by the CPU controller FSM.
- Holds the register file R0–R3, PC, IR, address register, ALU operand register Y and the flag register Z (zero/overflow).
- Routes data over two internal buses and drives the external single-port memory.
- Feeds the controller: instruction = IR, zero and over = registered flags.

Parameters:
- WIDTH, 8: data/address word width; all registers, buses and memory words.
- PC_RST, 0: PC value after reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load_r0, load_r1, load_r2, load_r3  in  1 each  load Rn from bus2
- load_pc  in  1  load PC from bus2
- inc_pc  in  1  PC <= PC+1
- load_ir  in  1  load IR from bus2
- load_a_reg  in  1  load address register from bus2
- load_reg_y  in  1  load Y from bus2
- load_reg_z  in  1  load zero/over flags from ALU
- write  in  1  memory write strobe
- s_b_mux1  in  3  bus1 select
- s_b_mux2  in  2  bus2 select
- mem_rdata  in  WIDTH  memory read data, combinational w.r.t. mem_addr
- mem_addr  out  WIDTH  = address register
- mem_wdata  out  WIDTH  = bus1
- mem_we  out  1  = write
- instruction  out  WIDTH  = IR
- zero  out  1  registered zero flag
- over  out  1  registered overflow flag

Behaviour:
- Reset (async):
  - R0–R3, IR, address register, Y, zero, over <= 0; PC <= PC_RST.
  - Outputs follow: mem_addr=0, instruction=0, mem_we=write.
- bus1 (combinational) by s_b_mux1:
  - 000/001/010/011 = R0/R1/R2/R3
  - 100 = PC
  - 101–111 = 0
- bus2 (combinational) by s_b_mux2:
  - 00 = ALU result
  - 01 = bus1
  - 10 = mem_rdata
  - 11 = 0
- Register loads:
  - All register loads are synchronous on the rising clk edge and capture bus2.
  - Any combination of loads may be asserted in the same cycle; each enabled register takes the same bus2 value.
  - Registers without an enable hold their value.
- PC:
  - load_pc has priority over inc_pc.
  - Increment wraps modulo 2^WIDTH (0xFF -> 0x00).
  - inc_pc with s_b_mux1=100 uses the pre-increment PC on bus1 in that cycle.
- ALU (combinational):
  - Operands: A = Y, B = bus1; operation from IR[7:4].
  - 0000 ADD: A+B; over = carry out.
  - 0001 SUB: A-B; over = borrow (A<B).
  - 0010 AND: A&B; over = 0.
  - 0011 NOT: ~A; over = 0.
  - 0100 OR: A|B; over = 0.
  - 0101 MUL: low WIDTH bits of A*B; over = 1 iff the high WIDTH bits are nonzero.
  - Any other opcode: result 0, over = 0.
  - ALU zero = (result == 0).
- Flags:
  - load_reg_z captures ALU zero and over together on the clock edge.
  - Flags otherwise hold their value; they are not affected by load, branch or memory operations.
- Memory:
  - mem_we = write, pass-through with no register stage.
  - mem_wdata = bus1; mem_addr = address register.
  - The write completes at the external memory on the clock edge where write=1.
  - A read is available on bus2 in the same cycle the address register holds the address, i.e. one cycle after load_a_reg.
- Latency:
  - Every register update is visible on the outputs one clock after its enable.
  - ALU, buses and mem_wdata are zero-latency combinational.
- Reset mid-operation: async reset overrides any in-flight load; the state above is restored immediately and no partial update remains.

Optional Feature:
- Macro: DP_SIGNED_OVF_EN.
- When defined, ADD/SUB overflow is two's-complement signed overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
- MUL and logic-op overflow behaviour is unchanged.
- When not defined, ADD/SUB use the unsigned carry/borrow rule above.

Test Plan:
- Reset with all registers preloaded to 0x5A -> R0–R3, IR, address register, Y = 0x00, PC = PC_RST, zero = 0, over = 0, immediately on rst rising.
- Instruction fetch: PC=0x10, mem[0x10]=0x07.
  - Cycle 1: load_a_reg with s_b_mux1=100, s_b_mux2=01 -> mem_addr=0x10.
  - Cycle 2: load_ir, inc_pc, s_b_mux2=10 -> instruction=0x07, PC=0x11.
- ADD with carry: Y=0xF0, R1=0x10, IR=0x01.
  - Cycle: load_r0 + load_reg_z, s_b_mux1=001, s_b_mux2=00 -> R0=0x00, zero=1, over=1 (with DP_SIGNED_OVF_EN: over=0).
- MUL: Y=0x10, R2=0x11, IR=0x52 -> result 0x10, over=1.
- MUL: Y=0x03, R2=0x04 -> result 0x0C, zero=0, over=0.
- Memory write: address register=0x20, R3=0xA5, write=1, s_b_mux1=011 -> mem_we=1, mem_wdata=0xA5, mem_addr=0x20 in that cycle; no internal register changes.
- PC priority/wrap:
  - PC=0xFF, inc_pc -> PC=0x00.
  - Next cycle load_pc+inc_pc, mem_rdata=0x42, s_b_mux2=10 -> PC=0x42 (load wins).
